act_pool_stage: RTL
===================

ACT_POOL_STAGE -- requirements
Module: act_pool_stage

Interface
REQ-001 SHALL have parameter CO, default 3: number of parallel channels.
REQ-002 SHALL have parameter I_BW, default 32: signed conv-result width per channel.
REQ-003 SHALL have parameter O_BW, default 16: signed output width per channel.
REQ-004 SHALL have parameter IF_SIZE, default 8: square input map side; must be a multiple of P_SIZE.
REQ-005 SHALL have parameter P_SIZE, default 2: pool window side; must be a power of two.
REQ-006 SHALL have parameter SH_BW, default 5: requant shift-amount width.
REQ-007 SHALL have port clk, input, 1: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port i_valid, input, 1: i_data beat valid.
REQ-010 SHALL have port i_data, input, CO*I_BW: raster-order pixel, channel c at [c*I_BW +: I_BW].
REQ-011 SHALL have port i_bias, input, CO*I_BW: per-channel signed bias.
REQ-012 SHALL have port i_relu_en, input, 1: 1 = apply ReLU.
REQ-013 SHALL have port i_pool_mode, input, 1: 0 = max, 1 = average.
REQ-014 SHALL have port i_shift, input, SH_BW: arithmetic right-shift amount for requantisation.
REQ-015 SHALL have port o_data, output, CO*O_BW: pooled, requantised result, same channel packing.
REQ-016 SHALL have port o_valid, output, 1: one-cycle pulse per pooled output.
REQ-017 SHALL have port o_end, output, 1: pulse coincident with o_valid on the last output of a frame.

Function
REQ-018 SHALL implement FSM IDLE/RUN; IDLE->RUN on first i_valid beat; RUN->IDLE after beat IF_SIZE*IF_SIZE-1 is consumed.
REQ-019 SHALL latch i_bias, i_relu_en, i_pool_mode, i_shift on the IDLE->RUN beat; config changes mid-frame take effect next frame.
REQ-020 SHALL keep column/row counters advancing only on i_valid; gaps of any length SHALL not alter results.
REQ-021 SHALL compute per channel: sign-extend to I_BW+1, add bias, then ReLU clamps negatives to 0 when enabled.
REQ-022 SHALL accumulate each P_SIZE x P_SIZE window via a horizontal accumulator plus a row buffer of IF_SIZE/P_SIZE partial entries per channel.
REQ-023 SHALL, in max mode, keep the signed maximum; in average mode, keep the sum (width I_BW+1+2*log2(P_SIZE)) and arithmetic-shift right by 2*log2(P_SIZE).
REQ-024 SHALL then arithmetic-shift right by latched i_shift (floor rounding) and saturate to signed O_BW range.
REQ-025 SHALL assert o_valid exactly 2 cycles after the beat completing a window (last column and last row of the window).
REQ-026 SHALL hold o_data stable between o_valid pulses.
REQ-027 SHALL assert o_end with the output of the window containing pixel (IF_SIZE-1, IF_SIZE-1).
REQ-028 SHALL accept a new frame's first beat in the cycle immediately following the previous frame's last beat, with no lost beat.

Reset
REQ-029 SHALL on rst asynchronously clear FSM to IDLE, counters, accumulators, row buffer, latched config, o_data=0, o_valid=0, o_end=0.
REQ-030 SHALL discard a partially received frame on mid-frame reset; in-flight outputs SHALL not appear.

Structure
REQ-031 SHALL place FSM state encoding and pool-mode constants (POOL_MAX, POOL_AVG) in a shared package.
REQ-032 SHALL use one sub-module, pool_chan, instantiated CO times (bias/ReLU/pool/requant datapath), with shared counters/FSM in the top.

Verification (CO=2, IF_SIZE=4, P_SIZE=2, O_BW=16 unless stated)
REQ-033 SHALL verify max mode with bias 0, shift 0, ReLU on, ch0 = pixel index 0..15: outputs 5,7,13,15; o_end with 15.
REQ-034 SHALL verify average mode with the same input: outputs 2,4,10,12.
REQ-035 SHALL verify all inputs -7, bias 0: ReLU on -> 0; ReLU off, max -> -7; ReLU off, avg -> -7.
REQ-036 SHALL verify saturation with O_BW=8, shift 2, ReLU off, max: input 1000 -> 127; input -1000 -> -128.
REQ-037 SHALL verify random i_valid gaps plus a config change mid-frame: outputs identical to REQ-033.
REQ-038 SHALL verify reset after 6 beats, then a full frame: exactly 4 o_valid pulses, values as REQ-033, no spurious pulse.

Source files
------------

// File: rtl/act_pool_stage_pkg.sv
// Shared types and constants for the activation + pooling stage.
// Holds the FSM encoding, pool-mode codes and the per-beat window-position record.
package act_pool_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    // Where a pixel sits inside its pooling window, carried one stage behind the beat.
    typedef struct packed {
        logic valid;
        logic first_col;
        logic last_col;
        logic first_row;
        logic last_row;
        logic frame_end;
    } pos_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_chan.sv
// One channel of the datapath: bias + ReLU, P x P window reduction (max or sum),
// then average scaling, requant shift and saturation into the registered output.
module pool_chan
    import act_pool_stage_pkg::*;
#(
    parameter int I_BW  = 32,
    parameter int O_BW  = 16,
    parameter int LOG2P = 1,
    parameter int NW    = 4,
    parameter int WC_W  = 2,
    parameter int SH_BW = 5,
    parameter int ACC_W = I_BW + 1 + 2 * LOG2P
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [I_BW-1:0]     i_pix,
    input  logic [I_BW-1:0]     i_bias,
    input  logic                i_relu_en,
    input  logic                i_s1_valid,
    input  logic                i_first_col,
    input  logic                i_last_col,
    input  logic                i_first_row,
    input  logic                i_last_row,
    input  logic [WC_W-1:0]     i_wcol,
    input  logic                i_pool_mode,
    input  logic [SH_BW-1:0]    i_shift,
    output logic [O_BW-1:0]     o_data
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

    logic signed [I_BW:0]    pre_q, pre_d;
    logic signed [I_BW:0]    sum;
    logic signed [ACC_W-1:0] h_acc_q, h_acc_d;
    logic signed [ACC_W-1:0] rb_q [NW];
    logic signed [ACC_W-1:0] rb_d [NW];
    logic signed [ACC_W-1:0] pix_ext, h_cmb, v_cmb, scaled, shifted;
    logic [O_BW-1:0]         data_q, data_d;

    // Max keeps the larger signed value; average keeps a running sum.
    function automatic logic signed [ACC_W-1:0] combine(
        input logic                    mode,
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        if (mode == POOL_AVG) begin
            return a + b;
        end
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        sum   = {i_pix[I_BW-1], i_pix} + {i_bias[I_BW-1], i_bias};
        pre_d = pre_q;
        if (i_valid) begin
            pre_d = (i_relu_en && sum[I_BW]) ? '0 : sum;
        end
    end

    always_comb begin
        pix_ext = ACC_W'(pre_q);
        h_cmb   = i_first_col ? pix_ext : combine(i_pool_mode, h_acc_q, pix_ext);
        v_cmb   = i_first_row ? h_cmb : combine(i_pool_mode, rb_q[i_wcol], h_cmb);
        scaled  = (i_pool_mode == POOL_AVG) ? (v_cmb >>> (2 * LOG2P)) : v_cmb;
        shifted = scaled >>> i_shift;

        h_acc_d = h_acc_q;
        rb_d    = rb_q;
        data_d  = data_q;
        if (i_s1_valid) begin
            if (!i_last_col) begin
                h_acc_d = h_cmb;
            end else if (!i_last_row) begin
                rb_d[i_wcol] = v_cmb;
            end else if (shifted > SAT_MAX) begin
                data_d = SAT_MAX[O_BW-1:0];
            end else if (shifted < SAT_MIN) begin
                data_d = SAT_MIN[O_BW-1:0];
            end else begin
                data_d = shifted[O_BW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            h_acc_q <= '0;
            data_q  <= '0;
            for (int i = 0; i < NW; i++) begin
                rb_q[i] <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            h_acc_q <= h_acc_d;
            data_q  <= data_d;
            rb_q    <= rb_d;
        end
    end

    assign o_data = data_q;

endmodule

// File: rtl/act_pool_stage.sv
// Raster-order activation + pooling stage: shared frame counters, config latch and
// FSM here, per-channel datapath in pool_chan. Results appear two cycles after a window closes.
module act_pool_stage
    import act_pool_stage_pkg::*;
#(
    parameter int CO      = 3,
    parameter int I_BW    = 32,
    parameter int O_BW    = 16,
    parameter int IF_SIZE = 8,
    parameter int P_SIZE  = 2,
    parameter int SH_BW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [CO*I_BW-1:0]   i_data,
    input  logic [CO*I_BW-1:0]   i_bias,
    input  logic                 i_relu_en,
    input  logic                 i_pool_mode,
    input  logic [SH_BW-1:0]     i_shift,
    output logic [CO*O_BW-1:0]   o_data,
    output logic                 o_valid,
    output logic                 o_end
);

    localparam int LOG2P = $clog2(P_SIZE);
    localparam int NW    = IF_SIZE / P_SIZE;
    localparam int COL_W = clog2_min1(IF_SIZE);
    localparam int WC_W  = clog2_min1(NW);
    localparam int ACC_W = I_BW + 1 + 2 * LOG2P;
    localparam logic [COL_W-1:0] PMASK    = COL_W'(P_SIZE - 1);
    localparam logic [COL_W-1:0] LAST_IDX = COL_W'(IF_SIZE - 1);

    // There is no backpressure: every cycle with i_valid high is one accepted
    // pixel beat, and o_valid is a single-cycle pulse the consumer must take.

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d, row_q, row_d;
    logic [CO*I_BW-1:0] bias_q, bias_d;
    logic               relu_q, relu_d, mode_q, mode_d;
    logic [SH_BW-1:0]   shift_q, shift_d;
    pos_t               s1_q, s1_d;
    logic [WC_W-1:0]    s1_wcol_q, s1_wcol_d;
    logic               o_valid_q, o_valid_d, o_end_q, o_end_d;

    logic               frame_last;
    logic               cfg_load;
    logic [CO*I_BW-1:0] bias_eff;
    logic               relu_eff;

    assign frame_last = (col_q == LAST_IDX) && (row_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid) state_d = frame_last ? ST_IDLE : ST_RUN;
            ST_RUN:  if (i_valid && frame_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The first beat of a frame is processed with the live config it also latches.
    always_comb begin
        cfg_load = (state_q == ST_IDLE) && i_valid;
        bias_eff = cfg_load ? i_bias : bias_q;
        relu_eff = cfg_load ? i_relu_en : relu_q;
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        bias_d    = bias_q;
        relu_d    = relu_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        s1_d      = '0;
        s1_wcol_d = s1_wcol_q;

        if (cfg_load) begin
            bias_d  = i_bias;
            relu_d  = i_relu_en;
            mode_d  = i_pool_mode;
            shift_d = i_shift;
        end

        if (i_valid) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + COL_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            s1_d.valid     = 1'b1;
            s1_d.first_col = (col_q & PMASK) == '0;
            s1_d.last_col  = (col_q & PMASK) == PMASK;
            s1_d.first_row = (row_q & PMASK) == '0;
            s1_d.last_row  = (row_q & PMASK) == PMASK;
            s1_d.frame_end = frame_last;
            s1_wcol_d      = WC_W'(col_q >> LOG2P);
        end

        o_valid_d = s1_q.valid && s1_q.last_col && s1_q.last_row;
        o_end_d   = o_valid_d && s1_q.frame_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
            mode_q    <= POOL_MAX;
            shift_q   <= '0;
            s1_q      <= '0;
            s1_wcol_q <= '0;
            o_valid_q <= 1'b0;
            o_end_q   <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            bias_q    <= bias_d;
            relu_q    <= relu_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            s1_q      <= s1_d;
            s1_wcol_q <= s1_wcol_d;
            o_valid_q <= o_valid_d;
            o_end_q   <= o_end_d;
        end
    end

    for (genvar c = 0; c < CO; c++) begin : g_chan
        pool_chan #(
            .I_BW  (I_BW),
            .O_BW  (O_BW),
            .LOG2P (LOG2P),
            .NW    (NW),
            .WC_W  (WC_W),
            .SH_BW (SH_BW),
            .ACC_W (ACC_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_valid     (i_valid),
            .i_pix       (i_data[c*I_BW +: I_BW]),
            .i_bias      (bias_eff[c*I_BW +: I_BW]),
            .i_relu_en   (relu_eff),
            .i_s1_valid  (s1_q.valid),
            .i_first_col (s1_q.first_col),
            .i_last_col  (s1_q.last_col),
            .i_first_row (s1_q.first_row),
            .i_last_row  (s1_q.last_row),
            .i_wcol      (s1_wcol_q),
            .i_pool_mode (mode_q),
            .i_shift     (shift_q),
            .o_data      (o_data[c*O_BW +: O_BW])
        );
    end

    assign o_valid = o_valid_q;
    assign o_end   = o_end_q;

endmodule
